// File: rtl/mips_perf_pkg.sv
// Shared types, default sizes and select helpers for the performance counter bank.
package mips_perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 32;

  // sel must be able to encode NUM_CH itself, which addresses the cycle shadow.
  function automatic int sel_width(input int num_ch);
    return (num_ch < 1) ? 1 : $clog2(num_ch + 1);
  endfunction

  // True when a select value addresses the cycle shadow rather than a channel.
  function automatic logic is_cycle_sel(input int sel_val, input int num_ch);
    return (sel_val == num_ch);
  endfunction

endpackage

// File: rtl/mips_perf_chan.sv
// One event channel: edge detect, counter with wrap/sticky overflow, snapshot shadow.
module mips_perf_chan
  import mips_perf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_en,
  input  logic             evt,
  input  logic             mode,
  input  logic             snap,
  output logic [CNT_W-1:0] shadow,
  output logic             ovf,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             prev_reg;
  logic             hit;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] shadow_reg;
  logic             ovf_reg;

  // Qualify the strobe and form the post-update count for this cycle.
  always_comb begin
    hit        = mode ? (evt & ~prev_reg) : evt;
    count_next = count_reg;
    wrap       = 1'b0;
    if (count_en && hit) begin
      count_next = count_reg + ONE;
      wrap       = &count_reg;
    end
  end

  // prev tracks the raw strobe in every state so edge mode never sees a stale level.
  always_ff @(posedge clk) begin
    if (rst) prev_reg <= 1'b0;
    else     prev_reg <= evt;
  end

  // Counter, sticky overflow and shadow; the shadow captures the post-update value.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg  <= '0;
      shadow_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (wrap) ovf_reg <= 1'b1;
      if (snap) shadow_reg <= count_next;
    end
  end

  assign shadow = shadow_reg;
  assign ovf    = ovf_reg;

endmodule

// File: rtl/mips_perf_counter.sv
// Cycle counter plus NUM_CH event channels under a run/halt FSM, with snapshot readback.
module mips_perf_counter
  import mips_perf_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter bit STOP_ON_OVF = 1'b0,
  parameter int SEL_W       = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              start,
  input  logic              stop,
  input  logic [NUM_CH-1:0] events,
  input  logic [NUM_CH-1:0] mode,
  input  logic              snap,
  input  logic [SEL_W-1:0]  sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic [CNT_W-1:0]  cycle,
  output logic              running,
  output logic              snap_valid
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_reg;
  state_t           state_next;
  logic             count_en;
  logic [NUM_CH-1:0] wrap_bus;
  logic [CNT_W-1:0] shadow_bus [NUM_CH];
  logic [CNT_W-1:0] cycle_reg;
  logic [CNT_W-1:0] cycle_next;
  logic [CNT_W-1:0] cycle_shadow_reg;
  logic [CNT_W-1:0] rd_data_reg;
  logic [CNT_W-1:0] rd_data_next;
  logic             snap_valid_reg;

  // A stop (or clear) on the same edge suppresses counting of that cycle's events.
  assign count_en = (state_reg == ST_RUN) && !stop && !clear;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      mips_perf_chan #(.CNT_W(CNT_W)) u_chan (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .count_en (count_en),
        .evt      (events[gi]),
        .mode     (mode[gi]),
        .snap     (snap),
        .shadow   (shadow_bus[gi]),
        .ovf      (ovf[gi]),
        .wrap     (wrap_bus[gi])
      );
    end
  endgenerate

  // Next state: clear overrides everything, stop beats start while running.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (stop || (STOP_ON_OVF && ((|ovf) || (|wrap_bus)))) state_next = ST_HALT;
      end
      ST_HALT: if (start) state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
    if (clear) state_next = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Free-running cycle count while running; it wraps without flagging.
  always_comb begin
    cycle_next = cycle_reg;
    if (count_en) cycle_next = cycle_reg + ONE;
  end

  // Cycle counter, its shadow and the snapshot strobe.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cycle_reg        <= '0;
      cycle_shadow_reg <= '0;
      snap_valid_reg   <= 1'b0;
    end else begin
      cycle_reg      <= cycle_next;
      snap_valid_reg <= snap;
      if (snap) cycle_shadow_reg <= cycle_next;
    end
  end

  // Readback mux over the registered shadows; unused select codes read zero.
  always_comb begin
    rd_data_next = '0;
    if (is_cycle_sel(int'(sel), NUM_CH)) rd_data_next = cycle_shadow_reg;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) rd_data_next = shadow_bus[i];
    end
  end

  // Readback register.
  always_ff @(posedge clk) begin
    if (rst || clear) rd_data_reg <= '0;
    else              rd_data_reg <= rd_data_next;
  end

  assign rd_data    = rd_data_reg;
  assign cycle      = cycle_reg;
  assign running    = (state_reg == ST_RUN);
  assign snap_valid = snap_valid_reg;

endmodule

// File: tb/tb_mips_perf_counter.sv
// Directed bench: a 32-bit bank plus two 8-bit banks (wrap / stop-on-overflow) on shared stimulus.
module tb_mips_perf_counter;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       start;
  logic       stop;
  logic [3:0] events;
  logic [3:0] mode;
  logic       snap;
  logic [2:0] sel;

  logic [31:0] rd_a, cyc_a;
  logic [3:0]  ovf_a;
  logic        run_a, sv_a;
  logic [7:0]  rd_b, cyc_b;
  logic [3:0]  ovf_b;
  logic        run_b, sv_b;
  logic [7:0]  rd_c, cyc_c;
  logic [3:0]  ovf_c;
  logic        run_c, sv_c;

  int checks = 0;
  int errors = 0;

  mips_perf_counter #(.NUM_CH(4), .CNT_W(32), .STOP_ON_OVF(1'b0)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .stop(stop),
    .events(events), .mode(mode), .snap(snap), .sel(sel),
    .rd_data(rd_a), .ovf(ovf_a), .cycle(cyc_a), .running(run_a), .snap_valid(sv_a)
  );

  mips_perf_counter #(.NUM_CH(4), .CNT_W(8), .STOP_ON_OVF(1'b0)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .stop(stop),
    .events(events), .mode(mode), .snap(snap), .sel(sel),
    .rd_data(rd_b), .ovf(ovf_b), .cycle(cyc_b), .running(run_b), .snap_valid(sv_b)
  );

  mips_perf_counter #(.NUM_CH(4), .CNT_W(8), .STOP_ON_OVF(1'b1)) dut_c (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .stop(stop),
    .events(events), .mode(mode), .snap(snap), .sel(sel),
    .rd_data(rd_c), .ovf(ovf_c), .cycle(cyc_c), .running(run_c), .snap_valid(sv_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) $display("check %s = %0h", tag, obs);
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; stop = 1'b0;
    events = 4'h0; mode = 4'h0; snap = 1'b0; sel = 3'd0;

    // Reset and idle: events without start must not count.
    repeat (3) step();
    chk("rst_cycle", cyc_a, 0);
    chk("rst_running", run_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_rd", rd_a, 0);
    chk("rst_snap_valid", sv_a, 0);
    rst = 1'b0; events = 4'hF;
    repeat (5) step();
    chk("idle_cycle", cyc_a, 0);
    chk("idle_running", run_a, 0);
    chk("idle_ovf", ovf_a, 0);
    snap = 1'b1; step(); snap = 1'b0;
    chk("idle_snap_valid", sv_a, 1);
    sel = 3'd4; step();
    chk("idle_rd_cycle", rd_a, 0);
    sel = 3'd0; step();
    chk("idle_rd_ch0", rd_a, 0);

    // Level vs edge mode: ch0 level, ch1 rising edge.
    events = 4'h0; mode = 4'b0010; start = 1'b1; step(); start = 1'b0;
    chk("le_running", run_a, 1);
    events = 4'b0011;
    repeat (6) step();
    chk("le_cycle_live", cyc_a, 6);
    events = 4'h0; stop = 1'b1; step(); stop = 1'b0;
    chk("le_stopped", run_a, 0);
    chk("le_cycle_frozen", cyc_a, 6);
    snap = 1'b1; step(); snap = 1'b0;
    chk("le_snap_valid", sv_a, 1);
    sel = 3'd0; step();
    chk("le_snap_valid_drop", sv_a, 0);
    chk("le_ch0_level", rd_a, 6);
    sel = 3'd1; step();
    chk("le_ch1_edge", rd_a, 1);
    sel = 3'd5; step();
    chk("le_sel_oob", rd_a, 0);
    sel = 3'd4; step();
    chk("le_cycle_shadow", rd_a, 6);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_rd", rd_a, 0);
    chk("clr_cycle", cyc_a, 0);

    // Snap in flight: snap at count 9 captures 10.
    mode = 4'h0; events = 4'b1000; start = 1'b1; step(); start = 1'b0;
    repeat (9) step();
    chk("fl_cycle9", cyc_a, 9);
    snap = 1'b1; step(); snap = 1'b0;
    chk("fl_snap_valid", sv_a, 1);
    chk("fl_cycle10", cyc_a, 10);
    sel = 3'd3; step();
    chk("fl_shadow3", rd_a, 10);
    chk("fl_live_cycle", cyc_a, 11);

    // Conflicts.
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("cf_startstop_halt", run_a, 0);
    chk("cf_startstop_cycle", cyc_a, 11);
    clear = 1'b1; snap = 1'b1; step(); clear = 1'b0; snap = 1'b0;
    chk("cf_clrsnap_valid", sv_a, 0);
    chk("cf_clrsnap_cycle", cyc_a, 0);
    step();
    chk("cf_clrsnap_shadow3", rd_a, 0);
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("cf_halt_cycle", cyc_a, 3);
    start = 1'b1; clear = 1'b1; step(); start = 1'b0; clear = 1'b0;
    chk("cf_startclr_running", run_a, 0);
    chk("cf_startclr_cycle", cyc_a, 0);
    repeat (2) step();
    chk("cf_idle_held", cyc_a, 0);

    // Wrap and overflow on the 8-bit banks.
    events = 4'b0100; start = 1'b1; step(); start = 1'b0;
    repeat (255) step();
    chk("wr_c_running255", run_c, 1);
    chk("wr_b_ovf255", ovf_b, 0);
    step();
    chk("wr_c_halted", run_c, 0);
    chk("wr_c_ovf", ovf_c, 4'b0100);
    chk("wr_c_cycle", cyc_c, 0);
    chk("wr_b_ovf", ovf_b, 4'b0100);
    chk("wr_b_running", run_b, 1);
    step();
    events = 4'h0; stop = 1'b1; step(); stop = 1'b0;
    snap = 1'b1; sel = 3'd2; step(); snap = 1'b0;
    step();
    chk("wr_b_ch2", rd_b, 1);
    chk("wr_c_ch2", rd_c, 0);
    chk("wr_a_ch2", rd_a, 257);
    chk("wr_a_ovf", ovf_a, 0);
    chk("wr_b_cycle", cyc_b, 1);
    chk("wr_a_cycle", cyc_a, 257);
    chk("wr_b_ovf_sticky", ovf_b, 4'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
